stream_mux_arb: RTL and testbench

- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of N input streams of W bits and presents it on a single registered output with valid/ready handshake.
- Two modes: round-robin arbitration among valid inputs, or manual select through a `sel` port, which is the 2:1 mux behaviour generalised.
- Sits between multiple producers and one shared consumer, e.g. several sensor or UART channels feeding one downstream FIFO.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/stream_mux_arb.sv | 96 +++++++++
 tb/tb_stream_mux_arb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream mux / arbiter slice.
package mux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  // Index width never collapses to zero, even for degenerate channel counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter import mux_pkg::*; #(
  parameter  int N    = 4,
  localparam int SELW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  localparam int SW1 = SELW + 1;

  logic [SW1-1:0]  sum;
  logic [SELW-1:0] idx;

  // ptr < N and k < N, so one conditional subtract is enough to wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW1'(k);
      if (sum >= SW1'(N)) sum = sum - SW1'(N);
      idx = sum[SELW-1:0];
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 stream mux with round-robin or manual select feeding one registered output.
module stream_mux_arb import mux_pkg::*; #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  localparam int SW1 = SELW + 1;

  logic [SELW-1:0] ptr_q;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [SELW-1:0] out_sel_q;

  logic [N-1:0]    arb_gnt;
  logic [SELW-1:0] arb_idx;
  logic            arb_any;

  logic [N-1:0]    sel_gnt;
  logic            sel_ok;
  logic [N-1:0]    grant;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_any;
  logic            load_en;
  logic            in_xfer;
  logic [W-1:0]    data_mux;
  logic [SELW-1:0] ptr_d;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // Manual grant looks only at the selected channel's valid; out-of-range sel never grants.
  assign sel_ok = ({1'b0, sel} < SW1'(N));

  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      sel_gnt[i] = sel_ok && (sel == SELW'(i)) && in_valid[i];
    end
  end

  assign grant   = (mode == MODE_SEL) ? sel_gnt : arb_gnt;
  assign gnt_idx = (mode == MODE_SEL) ? sel     : arb_idx;
  assign gnt_any = |grant;

  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign in_xfer  = rst_n && load_en && gnt_any;

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) data_mux = in_data[i*W +: W];
    end
  end

  assign ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_mux;
      out_sel_q   <= gnt_idx;
      if (mode == MODE_RR) ptr_q <= ptr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: directed table, hand corner sequences, random vs reference model.
module tb_stream_mux_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  stream_mux_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  vec_t tv[12];

  // Reference model state
  int          m_ptr;
  logic        m_v;
  logic [7:0]  m_d;
  int          m_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
  endtask

  // Asynchronous reset pulse, checked before any clock edge; leaves us at posedge+1.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rst_data"},  32'(out_data),  32'd0);
    chk({tag, "_rst_sel"},   32'(out_sel),   32'd0);
    chk({tag, "_rst_ready"}, 32'(in_ready),  32'd0);
    m_ptr = 0; m_v = 1'b0; m_d = '0; m_s = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One cycle: inputs already driven; check ready before the edge, outputs after.
  task automatic step_chk(input string tag, input logic [3:0] erdy, input logic ev,
                          input logic [7:0] ed, input logic [1:0] es);
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(erdy));
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_data"},  32'(out_data),  32'(ed));
    chk({tag, "_sel"},   32'(out_sel),   32'(es));
  endtask

  function automatic int model_grant(input logic m, input logic [1:0] s, input logic [3:0] v, input int ptr);
    if (m == 1'b0) begin
      for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
    end
    return v[s] ? int'(s) : -1;
  endfunction

  initial begin
    tv[0]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tv[1]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tv[2]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tv[3]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tv[4]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tv[5]  = '{1'b1, 1'b0, 2'd0, 4'b1010, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tv[6]  = '{1'b0, 1'b0, 2'd0, 4'b1010, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tv[7]  = '{1'b0, 1'b0, 2'd0, 4'b1010, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tv[8]  = '{1'b0, 1'b1, 2'd2, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tv[9]  = '{1'b0, 1'b1, 2'd2, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tv[10] = '{1'b0, 1'b1, 2'd2, 4'b1011, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    tv[11] = '{1'b0, 1'b1, 2'd2, 4'b1011, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};

    @(posedge clk); #1;
    do_reset("init");

    // Directed table: round-robin, sparse round-robin, manual select and drain
    for (int i = 0; i < 12; i++) begin
      if (tv[i].rst) do_reset($sformatf("tv%0d", i));
      drive(tv[i].mode, tv[i].sel, tv[i].valid, tv[i].data, tv[i].ordy);
      step_chk($sformatf("tv%0d", i), tv[i].exp_rdy, tv[i].exp_v, tv[i].exp_d, tv[i].exp_s);
    end

    // Backpressure, then reset asserted mid-stall
    do_reset("bp");
    drive(1'b0, 2'd0, 4'b0001, 32'h00000055, 1'b0);
    step_chk("bp_load", 4'b0001, 1'b1, 8'h55, 2'd0);
    drive(1'b0, 2'd0, 4'b0010, 32'h00006600, 1'b0);
    for (int c = 0; c < 3; c++) step_chk($sformatf("bp_stall%0d", c), 4'b0000, 1'b1, 8'h55, 2'd0);
    drive(1'b0, 2'd0, 4'b0010, 32'h00006600, 1'b1);
    step_chk("bp_drain_load", 4'b0010, 1'b1, 8'h66, 2'd1);
    drive(1'b0, 2'd0, 4'b0010, 32'h00007700, 1'b0);
    step_chk("bp_stall_again", 4'b0000, 1'b1, 8'h66, 2'd1);
    do_reset("midstall");

    // Mode switch: manual transfers must leave the round-robin pointer at 3
    drive(1'b0, 2'd0, 4'b1111, 32'hC3C2C1C0, 1'b1);
    step_chk("ms_rr0", 4'b0001, 1'b1, 8'hC0, 2'd0);
    step_chk("ms_rr1", 4'b0010, 1'b1, 8'hC1, 2'd1);
    step_chk("ms_rr2", 4'b0100, 1'b1, 8'hC2, 2'd2);
    drive(1'b1, 2'd0, 4'b1111, 32'hC3C2C1C0, 1'b1);
    step_chk("ms_sel0", 4'b0001, 1'b1, 8'hC0, 2'd0);
    step_chk("ms_sel1", 4'b0001, 1'b1, 8'hC0, 2'd0);
    drive(1'b0, 2'd0, 4'b1111, 32'hC3C2C1C0, 1'b1);
    step_chk("ms_back3", 4'b1000, 1'b1, 8'hC3, 2'd3);
    step_chk("ms_back0", 4'b0001, 1'b1, 8'hC0, 2'd0);

    // Random traffic against the reference model
    do_reset("rnd");
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        rm;
      logic [1:0]  rs;
      logic [3:0]  rv;
      logic [31:0] rd;
      logic        ro;
      int          g;
      logic [3:0]  erdy;
      if ($urandom_range(0, 49) == 0) do_reset($sformatf("rnd%0d", cyc));
      rm = ($urandom_range(0, 3) == 0);
      rs = 2'($urandom_range(0, 3));
      rv = 4'($urandom);
      rd = $urandom;
      ro = ($urandom_range(0, 3) != 0);
      drive(rm, rs, rv, rd, ro);
      g = model_grant(rm, rs, rv, m_ptr);
      erdy = ((!m_v || ro) && g >= 0) ? 4'(1 << g) : 4'b0000;
      if (erdy != 4'b0000) begin
        m_v = 1'b1;
        m_d = rd[g*W +: W];
        m_s = g;
        if (rm == 1'b0) m_ptr = (g + 1) % N;
      end else if (ro) begin
        m_v = 1'b0;
      end
      step_chk($sformatf("rnd%0d", cyc), erdy, m_v, m_d, 2'(m_s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
